// File: rtl/elevator_pkg.sv
// Shared definitions for the floor call dispatcher: FSM state encoding,
// travel direction codes, floor number width and the default floor count.
// No logic lives here; every dispatcher file imports this package.
package elevator_pkg;

  localparam int FLOOR_W      = 3;   // floors 1..7 fit, 0 means "unknown/none"
  localparam int N_FLOORS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_TRAVEL = 2'd2,
    ST_DOOR   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

endpackage

// File: rtl/scan_select.sv
// SCAN target choice: nearest pending floor in the last travel direction,
// else nearest pending floor in the opposite direction. Purely combinational.
// No handshake; the result is sampled by the dispatcher FSM in IDLE.
// Ports: pending (call latch), current_floor, last_dir (dir code) in;
//        floor (chosen floor, 0 if none), found out.
import elevator_pkg::*;

module scan_select #(
  parameter int N_FLOORS = N_FLOORS_DEF
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]  current_floor,
  input  logic [1:0]          last_dir,
  output logic [FLOOR_W-1:0]  floor,
  output logic                found
);

  logic [FLOOR_W-1:0] up_floor;
  logic [FLOOR_W-1:0] dn_floor;
  logic               up_found;
  logic               dn_found;

  always_comb begin
    up_floor = '0;
    up_found = 1'b0;
    dn_floor = '0;
    dn_found = 1'b0;
    // Walk downward so the last hit above the car is the closest one.
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i + 1) > current_floor)) begin
        up_floor = FLOOR_W'(i + 1);
        up_found = 1'b1;
      end
    end
    // Walk upward so the last hit below the car is the closest one.
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i + 1) < current_floor)) begin
        dn_floor = FLOOR_W'(i + 1);
        dn_found = 1'b1;
      end
    end
  end

  always_comb begin
    floor = '0;
    found = 1'b0;
    if (last_dir == DIR_DOWN) begin
      if (dn_found) begin
        floor = dn_floor;
        found = 1'b1;
      end else if (up_found) begin
        floor = up_floor;
        found = 1'b1;
      end
    end else begin
      if (up_found) begin
        floor = up_floor;
        found = 1'b1;
      end else if (dn_found) begin
        floor = dn_floor;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floor_call_dispatcher.sv
// Elevator call dispatcher: latches floor calls, picks SCAN targets, runs the door timer.
// Latency: call edge -> pending next cycle; pending -> target_valid one cycle later.
// Backpressure: target held stable while target_ready is low; calls keep latching meanwhile.
// Ports: iCLK/iRST (async active-high), call_btn, current_floor, arrived, target_ready in;
//        target_floor/target_valid, pending (lamps), door_open, dir out.
import elevator_pkg::*;

module floor_call_dispatcher #(
  parameter int N_FLOORS    = N_FLOORS_DEF,
  parameter int DOOR_CYCLES = 100000000
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [N_FLOORS-1:0] call_btn,
  input  logic [2:0]          current_floor,
  input  logic                arrived,
  input  logic                target_ready,
  output logic [2:0]          target_floor,
  output logic                target_valid,
  output logic [N_FLOORS-1:0] pending,
  output logic                door_open,
  output logic [1:0]          dir
);

  localparam int                CNT_W     = $clog2(DOOR_CYCLES + 1);
  // Counter holds the number of door cycles still to go after the current one.
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);

  state_t             state;
  dir_t               last_dir;
  logic [2:0]         tgt;        // accepted target, kept after target_floor drops to 0
  logic [N_FLOORS-1:0] btn_q;
  logic [CNT_W-1:0]   door_cnt;

  logic [N_FLOORS-1:0] call_edge;
  logic [N_FLOORS-1:0] cur_bit;
  logic [N_FLOORS-1:0] tgt_bit;
  logic [N_FLOORS-1:0] set_mask;
  logic [N_FLOORS-1:0] clr_mask;
  logic                cur_hit;
  logic                door_restart;
  logic [2:0]          scan_floor;
  logic                scan_found;

  scan_select #(.N_FLOORS(N_FLOORS)) u_scan (
    .pending       (pending),
    .current_floor (current_floor),
    .last_dir      (last_dir),
    .floor         (scan_floor),
    .found         (scan_found)
  );

  always_comb begin
    cur_bit = '0;
    tgt_bit = '0;
    // Floor 0 or an out-of-range floor decodes to no bit at all.
    for (int i = 0; i < N_FLOORS; i++) begin
      cur_bit[i] = (current_floor == 3'(i + 1));
      tgt_bit[i] = (tgt == 3'(i + 1));
    end
    call_edge    = call_btn & ~btn_q;
    cur_hit      = (state == ST_IDLE) && |(pending & cur_bit);
    door_restart = (state == ST_DOOR) && |(call_edge & cur_bit);
    // A call for the floor the door is open at only extends the door.
    set_mask     = (state == ST_DOOR) ? (call_edge & ~cur_bit) : call_edge;
    clr_mask     = '0;
    if (cur_hit)
      clr_mask = cur_bit;
    else if ((state == ST_TRAVEL) && arrived)
      clr_mask = tgt_bit;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state        <= ST_IDLE;
      last_dir     <= DIR_UP;
      tgt          <= '0;
      btn_q        <= '0;
      door_cnt     <= '0;
      pending      <= '0;
      target_floor <= '0;
      target_valid <= 1'b0;
      door_open    <= 1'b0;
      dir          <= DIR_IDLE;
    end else begin
      btn_q   <= call_btn;
      // Clear is applied last so it wins over a same-cycle call edge.
      pending <= (pending | set_mask) & ~clr_mask;
      case (state)
        ST_IDLE: begin
          if (cur_hit) begin
            state     <= ST_DOOR;
            door_open <= 1'b1;
            door_cnt  <= DOOR_LAST;
            dir       <= DIR_IDLE;
          end else if (scan_found && (current_floor != 3'd0)) begin
            state        <= ST_ISSUE;
            tgt          <= scan_floor;
            target_floor <= scan_floor;
            target_valid <= 1'b1;
            if (scan_floor > current_floor) begin
              dir      <= DIR_UP;
              last_dir <= DIR_UP;
            end else begin
              dir      <= DIR_DOWN;
              last_dir <= DIR_DOWN;
            end
          end else begin
            dir <= DIR_IDLE;
          end
        end
        ST_ISSUE: begin
          if (target_ready) begin
            state        <= ST_TRAVEL;
            target_valid <= 1'b0;
            target_floor <= '0;
          end
        end
        ST_TRAVEL: begin
          if (arrived) begin
            state     <= ST_DOOR;
            door_open <= 1'b1;
            door_cnt  <= DOOR_LAST;
            dir       <= DIR_IDLE;
          end
        end
        ST_DOOR: begin
          if (door_restart) begin
            door_cnt <= DOOR_LAST;
          end else if (door_cnt == '0) begin
            state     <= ST_IDLE;
            door_open <= 1'b0;
          end else begin
            door_cnt <= door_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
